alu_xor_descrambler: RTL and testbench



---
 rtl/alu_xor_pkg.sv | 18 +
 rtl/alu_xor_keystream.sv | 30 +++
 rtl/alu_xor_descrambler.sv | 100 ++++++++++
 tb/tb_alu_xor_descrambler.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/alu_xor_pkg.sv
// Shared types and keystream generator for the 32-bit XOR scramble/descramble datapath.
package alu_xor_pkg;

  localparam int          WORD_W       = 32;
  localparam logic [31:0] DEFAULT_SEED = 32'h2545F491;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  // xorshift32 step; shifts are logical and truncated to 32 bits
  function automatic logic [31:0] xorshift32(logic [31:0] s);
    logic [31:0] t;
    t = s ^ (s << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

endpackage

// File: rtl/alu_xor_keystream.sv
// Keystream state register: seed mux with zero-seed substitution, advances one step per accepted word.
module alu_xor_keystream #(
  parameter logic [31:0] DEFAULT_SEED = alu_xor_pkg::DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] ks
);
  import alu_xor_pkg::*;

  logic [31:0] ks_d, ks_q;

  // load and advance are mutually exclusive: the top blocks accepts during a seed load
  always_comb begin
    ks_d = ks_q;
    if (load)         ks_d = (seed == '0) ? DEFAULT_SEED : seed;
    else if (advance) ks_d = xorshift32(ks_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ks_q <= DEFAULT_SEED;
    else        ks_q <= ks_d;
  end

  assign ks = ks_q;

endmodule

// File: rtl/alu_xor_descrambler.sv
// Receive-side XOR descrambler: valid/ready stream, one registered output stage, seed-load FSM.
// Optional parity check on the scrambled word enabled by defining ALU_XOR_DESCR_PARITY_EN.
module alu_xor_descrambler #(
  parameter int          WIDTH        = alu_xor_pkg::WORD_W,
  parameter int          CNT_W        = 16,
  parameter logic [31:0] DEFAULT_SEED = alu_xor_pkg::DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [31:0]      seed,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_parity,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_perr,
  output logic [CNT_W-1:0] word_cnt,
  output logic             running
);
  import alu_xor_pkg::*;

  state_e             state_d, state_q;
  logic               out_valid_d, out_valid_q;
  logic [WIDTH-1:0]   out_data_d, out_data_q;
  logic [CNT_W-1:0]   word_cnt_d, word_cnt_q;
  logic [31:0]        ks;
  logic               accept;

  // seed_load blocks acceptance so no word ever sees a half-loaded keystream
  assign in_ready = (state_q == RUN) && !seed_load && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  alu_xor_keystream #(.DEFAULT_SEED(DEFAULT_SEED)) u_ks (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (seed_load),
    .seed    (seed),
    .advance (accept),
    .ks      (ks)
  );

  always_comb begin
    state_d     = seed_load ? RUN : state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    word_cnt_d  = word_cnt_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data ^ ks;
      word_cnt_d  = word_cnt_q + 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (seed_load) word_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

`ifdef ALU_XOR_DESCR_PARITY_EN
  logic out_perr_d, out_perr_q;

  // parity is checked on the scrambled word as it arrived on the link
  always_comb begin
    out_perr_d = out_perr_q;
    if (accept) out_perr_d = ^in_data ^ in_parity;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_perr_q <= 1'b0;
    else        out_perr_q <= out_perr_d;
  end

  assign out_perr = out_perr_q;
`else
  logic unused_parity;
  assign unused_parity = in_parity;
  assign out_perr      = 1'b0;
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign word_cnt  = word_cnt_q;
  assign running   = (state_q == RUN);

endmodule

// File: tb/tb_alu_xor_descrambler.sv
// Directed + randomized bench for alu_xor_descrambler against a cycle-level behavioural model.
module tb_alu_xor_descrambler;
  import alu_xor_pkg::*;

  localparam int CW = 4;
`ifdef ALU_XOR_DESCR_PARITY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          seed_load = 1'b0, in_valid = 1'b0, in_parity = 1'b0, out_ready = 1'b0;
  logic [31:0]   seed = '0, in_data = '0;
  logic          in_ready, out_valid, out_perr, running;
  logic [31:0]   out_data;
  logic [CW-1:0] word_cnt;

  int total = 0;
  int bad   = 0;

  // model state: keystream word for the next accept, output register image, counter
  logic [31:0] m_ks, m_data;
  bit          m_run, m_ov, m_perr;
  int          m_cnt;

  always #5 clk = ~clk;

  alu_xor_descrambler #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_parity(in_parity),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_perr(out_perr),
    .word_cnt(word_cnt), .running(running)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_ov = 0; m_perr = 0; m_data = '0; m_cnt = 0; m_ks = DEFAULT_SEED;
  endtask

  task automatic check_outs(string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_ov));
    chk({tag, ".out_data"},  out_data,       m_data);
    chk({tag, ".out_perr"},  32'(out_perr),  32'(m_perr));
    chk({tag, ".word_cnt"},  32'(word_cnt),  32'(m_cnt));
    chk({tag, ".running"},   32'(running),   32'(m_run));
  endtask

  // one clock: drive, check in_ready, clock, advance model, check registered outputs
  task automatic cyc(string tag, bit v, logic [31:0] d, bit p, bit r, bit sl, logic [31:0] sd);
    bit exp_rdy, acc;
    in_valid = v; in_data = d; in_parity = p; out_ready = r; seed_load = sl; seed = sd;
    #1;
    exp_rdy = m_run && !sl && (!m_ov || r);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
    acc = v && exp_rdy;
    @(posedge clk); #1;
    if (acc) begin
      m_data = d ^ m_ks;
      m_perr = PEN ? (^d ^ p) : 1'b0;
      m_ks   = xorshift32(m_ks);
      m_cnt  = (m_cnt + 1) % (1 << CW);
      m_ov   = 1;
    end else if (r) begin
      m_ov = 0;
    end
    if (sl) begin
      m_ks  = (sd == 0) ? DEFAULT_SEED : sd;
      m_cnt = 0;
      m_run = 1;
    end
    check_outs(tag);
  endtask

  initial begin
    logic [31:0] held;
    model_reset();
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    check_outs("reset");
    chk("reset.in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;

    // IDLE ignores input until a seed is loaded
    cyc("idle", 1, 32'h1234_5678, 0, 1, 0, 0);
    cyc("load1", 1, 32'h1, 0, 1, 1, 32'h1);
    cyc("w0", 1, 32'h0000_0001, 0, 1, 0, 0);
    chk("seed1.w0", out_data, 32'h0);
    cyc("w1", 1, 32'h0004_2021, 0, 1, 0, 0);
    chk("seed1.w1", out_data, 32'h0);
    chk("seed1.cnt", 32'(word_cnt), 32'd2);

    // backpressure: output holds, keystream must not advance
    held = m_data;
    for (int i = 0; i < 5; i++) begin
      cyc("stall", 1, $urandom, 1'($urandom), 0, 0, 0);
      chk("stall.hold", out_data, held);
      chk("stall.rdy", 32'(in_ready), 32'd0);
    end
    for (int i = 0; i < 4; i++) cyc("release", 1, $urandom, 1'($urandom), 1, 0, 0);

    // zero seed substitutes the default
    cyc("load0", 1, 32'hFFFF_FFFF, 0, 1, 1, 32'h0);
    chk("load0.rdy", 32'(in_ready), 32'd0);
    cyc("def.w0", 1, 32'h2545_F491, 0, 1, 0, 0);
    chk("def.w0.data", out_data, 32'h0);

    // counter wraps modulo 2^CW
    cyc("load_w", 0, 0, 0, 1, 1, $urandom);
    for (int i = 0; i < 17; i++) cyc("wrap", 1, $urandom, 0, 1, 0, 0);
    chk("wrap.cnt", 32'(word_cnt), 32'd1);

    // parity on the scrambled word
    cyc("par0", 1, 32'h0000_0003, 0, 1, 0, 0);
    chk("par0.perr", 32'(out_perr), 32'(1'b0));
    cyc("par1", 1, 32'h0000_0003, 1, 1, 0, 0);
    chk("par1.perr", 32'(out_perr), 32'(PEN));

    // randomized traffic with occasional reseeds
    for (int i = 0; i < 300; i++) begin
      bit sl;
      sl = ($urandom_range(0, 29) == 0);
      cyc("rand", 1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom),
          1'($urandom_range(0, 3) != 0), sl, ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom);
    end

    // async reset mid-stream while a word is held
    cyc("pre_rst", 1, $urandom, 0, 0, 0, 0);
    cyc("pre_rst2", 1, $urandom, 0, 0, 0, 0);
    chk("pre_rst.ov", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst.ov", 32'(out_valid), 32'd0);
    chk("arst.run", 32'(running), 32'd0);
    chk("arst.data", out_data, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc("post_rst", 1, $urandom, 0, 1, 0, 0);
    cyc("reload", 1, 0, 0, 1, 1, 32'h1);
    cyc("reload.w0", 1, 32'h0000_0001, 0, 1, 0, 0);
    chk("reload.data", out_data, 32'h0);
    cyc("drain", 0, 0, 0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
